stream_demux_switch: RTL and testbench
======================================

Name: stream_demux_switch

Overview:
- Registered, parametrised 1-to-NCH stream demultiplexer; the sequential successor to the combinational two-way data switch.
- Routes each accepted input word to the output channel chosen by in_sel.
- Each channel has a one-entry holding register with a valid/ready handshake.
- Sits between a single producer and NCH independent consumers in the datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- NCH, 4, number of output channels (>=2).
- SELW, $clog2(NCH), width of in_sel; derived, never overridden.
- CNTW, 16, width of each per-channel statistics counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  switch accepts the word this cycle.
- in_sel  in  SELW  destination channel index; sampled with in_valid.
- in_data  in  WIDTH  input word.
- out_valid  out  NCH  bit k: channel k holds a word.
- out_ready  in  NCH  bit k: consumer k takes the word.
- out_data  out  NCH*WIDTH  channel k at [k*WIDTH +: WIDTH].
- drop_err  out  1  sticky: a word with in_sel >= NCH was discarded.
- err_clr  in  1  synchronous clear of drop_err.

Behaviour:
- Reset (async assert, sync release): all out_valid=0, all out_data=0, drop_err=0. Words held at reset assertion are lost; no partial state survives.
- Channel k holding register:
  - full[k] drives out_valid[k].
  - out_data slice is zero whenever full[k]=0, so non-selected channels read 0.
- in_ready (combinational from in_sel, full, out_ready):
  - in_sel < NCH: in_ready = ~full[in_sel] | out_ready[in_sel].
  - in_sel >= NCH: in_ready = 1.
  - No dependency on in_valid.
- Accept = in_valid & in_ready. On accept with valid sel:
  - register[in_sel] <= in_data; full[in_sel] <= 1.
  - Latency is 1 cycle: the word is visible on out_data the next cycle.
- Drain = out_valid[k] & out_ready[k].
  - Drain without fill: full[k] <= 0, data[k] <= 0.
  - Drain and fill of the same channel in the same cycle: new word loads, out_valid[k] stays 1, no bubble. Full throughput on one channel is 1 word/cycle.
- Drains on different channels are independent and may all occur in one cycle. At most one fill per cycle.
- Invalid sel (in_sel >= NCH, only possible when NCH is not a power of 2):
  - The word is accepted and discarded; no channel changes.
  - drop_err <= 1 on the next edge.
- err_clr=1 clears drop_err. If a drop occurs in the same cycle as err_clr, set wins and drop_err=1.
- in_data/in_sel are don't-care when in_valid=0. out_data is stable while out_valid=1 and out_ready=0.
- Ordering: words to the same channel leave in acceptance order. There is no ordering across channels.

Optional Feature:
- Macro: STREAM_DEMUX_SWITCH_STATS_EN.
- Defined:
  - Adds ports stats_clr (in, 1) and stats_cnt (out, NCH*CNTW; channel k at [k*CNTW +: CNTW]).
  - stats_cnt[k] increments by 1 on each drain of channel k and saturates at 2^CNTW-1 (no wrap).
  - stats_clr=1 zeroes all counters. A drain in the same cycle as stats_clr leaves the counter at 0; clear wins.
  - Counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-stream with channel 2 full -> out_valid=0, out_data=0, drop_err=0 immediately without a clock edge; after release, in_ready=1 for every sel.
- Basic routing: NCH=4, in_valid=1 with sel=0..3 sequentially, data 0xA0..0xA3, all out_ready=1 -> each word appears on its own channel exactly one cycle after accept; other channels read 0.
- Backpressure: sel=1, out_ready[1]=0, send 0x11 then 0x22 -> 0x11 held, in_ready=0 for sel=1 while in_ready=1 for sel=3. Raise out_ready[1] -> 0x11 drains and 0x22 loads in the same cycle; out_valid[1] never drops.
- Streaming: sel=2, out_ready[2]=1, in_valid held for 8 cycles, data 1..8 -> 8 words accepted in 8 consecutive cycles, received in order 1..8.
- Invalid sel: NCH=3, sel=3, data 0xFF -> in_ready=1, no out_valid change, drop_err=1 next cycle. Assert err_clr together with another sel=3 -> drop_err remains 1. err_clr alone -> 0.
- Stats (macro on, CNTW=4): 17 drains on channel 0 -> stats_cnt[0]=15 (saturated). stats_clr together with a drain -> stats_cnt[0]=0.

Source files
------------

// File: rtl/stream_demux_switch.sv
// Registered 1-to-NCH stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel drain counters are enabled by defining STREAM_DEMUX_SWITCH_STATS_EN.
module stream_demux_switch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
`ifdef STREAM_DEMUX_SWITCH_STATS_EN
    ,
    parameter int CNTW  = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SELW-1:0]        in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic                   drop_err,
`ifdef STREAM_DEMUX_SWITCH_STATS_EN
    input  logic                   stats_clr,
    output logic [NCH*CNTW-1:0]    stats_cnt,
`endif
    input  logic                   err_clr
);

    // The select space is padded to a power of two so indexing with any
    // in_sel value stays in range; indices >= NCH are marked invalid.
    localparam int NSEL = 1 << SELW;

    logic [NSEL-1:0] sel_ok;
    logic [NSEL-1:0] full_pad;
    logic [NSEL-1:0] ready_pad;
    logic [NCH-1:0]  full_vec;

    logic accept;
    logic fill_any;
    logic drop;
    logic drop_err_q;
    logic drop_err_d;

    genvar gi;

    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_pad
            if (gi < NCH) begin : g_real
                assign sel_ok[gi]    = 1'b1;
                assign full_pad[gi]  = full_vec[gi];
                assign ready_pad[gi] = out_ready[gi];
            end else begin : g_void
                assign sel_ok[gi]    = 1'b0;
                assign full_pad[gi]  = 1'b0;
                assign ready_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Invalid selects are always accepted so the producer never stalls on them.
    assign in_ready = ~sel_ok[in_sel] | ~full_pad[in_sel] | ready_pad[in_sel];
    assign accept   = in_valid & in_ready;
    assign fill_any = accept & sel_ok[in_sel];
    assign drop     = accept & ~sel_ok[in_sel];

    // A drop in the same cycle as err_clr keeps the flag set.
    always_comb begin
        drop_err_d = drop_err_q;
        if (drop) begin
            drop_err_d = 1'b1;
        end else if (err_clr) begin
            drop_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_err = drop_err_q;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic             fill;
            logic             drain;
            logic             full_q;
            logic             full_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            assign fill  = fill_any & (in_sel == SELW'(gi));
            assign drain = full_q & out_ready[gi];

            // Fill takes priority so a simultaneous drain and fill keeps the
            // channel full with the new word and no bubble.
            always_comb begin
                full_d = full_q;
                data_d = data_q;
                if (fill) begin
                    full_d = 1'b1;
                    data_d = in_data;
                end else if (drain) begin
                    full_d = 1'b0;
                    data_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    full_q <= full_d;
                    data_q <= data_d;
                end
            end

            assign full_vec[gi]                   = full_q;
            assign out_valid[gi]                  = full_q;
            assign out_data[gi*WIDTH +: WIDTH]    = data_q;

`ifdef STREAM_DEMUX_SWITCH_STATS_EN
            logic [CNTW-1:0] cnt_q;
            logic [CNTW-1:0] cnt_d;

            // Saturating drain counter; clear beats a same-cycle drain.
            always_comb begin
                cnt_d = cnt_q;
                if (stats_clr) begin
                    cnt_d = '0;
                end else if (drain && (cnt_q != {CNTW{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stats_cnt[gi*CNTW +: CNTW] = cnt_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_stream_demux_switch.sv
// Directed and randomized bench for stream_demux_switch (NCH=4 and NCH=3 instances)
// against a per-channel slot model.
module tb_stream_demux_switch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_ready;
    logic        err_clr;
    logic        stats_clr;
    logic        use3;

    logic        irdy4, irdy3, de4, de3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;

    logic        obs_ready, obs_err;
    logic [3:0]  obs_valid;
    logic [31:0] obs_data;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;

    // Reference model: each channel is a slot that is either empty or holds one word.
    int         nch;
    bit         m_full [4];
    logic [7:0] m_data [4];
    bit         m_drop;
    int         m_cnt  [4];

    always #5 clk = ~clk;

`ifdef STREAM_DEMUX_SWITCH_STATS_EN
    logic [15:0] sc4;
    logic [11:0] sc3;
    logic [15:0] obs_cnt;

    stream_demux_switch #(.WIDTH(8), .NCH(4), .CNTW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~use3), .in_ready(irdy4),
        .in_sel(in_sel), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .drop_err(de4), .stats_clr(stats_clr), .stats_cnt(sc4),
        .err_clr(err_clr)
    );
    stream_demux_switch #(.WIDTH(8), .NCH(3), .CNTW(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & use3), .in_ready(irdy3),
        .in_sel(in_sel), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_data(od3), .drop_err(de3), .stats_clr(stats_clr), .stats_cnt(sc3),
        .err_clr(err_clr)
    );
    assign obs_cnt = use3 ? {4'h0, sc3} : sc4;
`else
    stream_demux_switch #(.WIDTH(8), .NCH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~use3), .in_ready(irdy4),
        .in_sel(in_sel), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .drop_err(de4), .err_clr(err_clr)
    );
    stream_demux_switch #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & use3), .in_ready(irdy3),
        .in_sel(in_sel), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_data(od3), .drop_err(de3), .err_clr(err_clr)
    );
`endif

    assign obs_ready = use3 ? irdy3 : irdy4;
    assign obs_valid = use3 ? {1'b0, ov3} : ov4;
    assign obs_data  = use3 ? {8'h00, od3} : od4;
    assign obs_err   = use3 ? de3 : de4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
            m_cnt[k]  = 0;
        end
        m_drop = 1'b0;
    endtask

    function automatic bit model_ready();
        if (int'(in_sel) >= nch) return 1'b1;
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    task automatic check_outputs();
        logic [31:0] ev;
        logic [31:0] ed;
        ev = '0;
        ed = '0;
        for (int k = 0; k < 4; k++) begin
            ev[k]       = m_full[k];
            ed[k*8 +: 8] = m_data[k];
        end
        check("out_valid", 32'(obs_valid), ev);
        check("out_data", obs_data, ed);
        check("drop_err", 32'(obs_err), 32'(m_drop));
`ifdef STREAM_DEMUX_SWITCH_STATS_EN
        for (int k = 0; k < 4; k++) begin
            check("stats_cnt", 32'(obs_cnt[k*4 +: 4]), 32'(m_cnt[k]));
        end
`endif
    endtask

    // One clock: check in_ready, advance model across the edge, check outputs.
    task automatic step();
        bit er;
        bit acc;
        bit drained;
        #1;
        er  = model_ready();
        check("in_ready", 32'(obs_ready), 32'(er));
        acc = in_valid && er;
        if (acc) n_acc++;
        @(posedge clk);
        for (int k = 0; k < nch; k++) begin
            drained = m_full[k] && out_ready[k];
            if (drained) begin
                m_full[k] = 1'b0;
                m_data[k] = 8'h00;
            end
            if (stats_clr) m_cnt[k] = 0;
            else if (drained && m_cnt[k] < 15) m_cnt[k]++;
        end
        if (acc && int'(in_sel) < nch) begin
            m_full[in_sel] = 1'b1;
            m_data[in_sel] = in_data;
        end
        if (acc && int'(in_sel) >= nch) m_drop = 1'b1;
        else if (err_clr) m_drop = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            err_clr   = ($urandom_range(0, 15) == 0);
            stats_clr = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        stats_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
        out_ready = 4'h0; err_clr = 1'b0; stats_clr = 1'b0; use3 = 1'b0;
        nch = 4;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
        @(negedge clk);

        // Reset asserted mid-stream with channel 2 holding a word.
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A; out_ready = 4'h0;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(obs_valid), 32'h4);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(obs_valid), 32'h0);
        check("rst_data", obs_data, 32'h0);
        check("rst_err", 32'(obs_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("rst_in_ready", 32'(obs_ready), 32'h1);
        end
        @(negedge clk);

        // Basic routing, one word per channel.
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel  = 2'(s);
            in_data = 8'(8'hA0 + s);
            step();
            check("route_valid", 32'(obs_valid), 32'(1 << s));
            check("route_data", obs_data, 32'(8'hA0 + s) << (8 * s));
        end
        in_valid = 1'b0;
        step();

        // Backpressure on channel 1.
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        check("bp_held", 32'(obs_data[15:8]), 32'h11);
        in_sel = 2'd3;
        #1;
        check("bp_ready_sel3", 32'(obs_ready), 32'h1);
        in_sel = 2'd1;
        #1;
        check("bp_ready_sel1", 32'(obs_ready), 32'h0);
        out_ready = 4'hF;
        step();
        check("bp_swap_valid", 32'(obs_valid[1]), 32'h1);
        check("bp_swap_data", 32'(obs_data[15:8]), 32'h22);
        in_valid = 1'b0;
        step();

        // Streaming eight words through channel 2.
        n_acc = 0;
        in_valid = 1'b1; in_sel = 2'd2;
        for (int i = 1; i <= 8; i++) begin
            in_data = 8'(i);
            step();
            check("stream_data", 32'(obs_data[23:16]), 32'(i));
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(n_acc), 32'd8);
        step();

`ifdef STREAM_DEMUX_SWITCH_STATS_EN
        // Saturation after 17 drains, then clear racing a drain.
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'hF;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("stats_sat", 32'(obs_cnt[3:0]), 32'd15);
        in_valid = 1'b1; in_data = 8'h77;
        step();
        in_valid = 1'b0; stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("stats_clr_wins", 32'(obs_cnt[3:0]), 32'd0);
`endif

        random_steps(300);

        // Switch to the three-channel instance.
        rst_n = 1'b0;
        use3 = 1'b1;
        nch = 3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h33;
        step();
        in_sel = 2'd3; in_data = 8'hFF;
        step();
        check("drop_valid", 32'(obs_valid), 32'h1);
        check("drop_set", 32'(obs_err), 32'h1);
        err_clr = 1'b1;
        step();
        check("drop_set_wins", 32'(obs_err), 32'h1);
        in_valid = 1'b0;
        step();
        check("drop_cleared", 32'(obs_err), 32'h0);
        err_clr = 1'b0;

        random_steps(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
